mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter: MAX_WAIT, default 15, maximum BUSY cycles allowed without mem_ack before abort (1..255).
REQ-002 SHALL have port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports from EX/MEM: valid_in 1, PC_in_mem 32, Inst_in_mem 32, WBSel_in_mem 2, ALUOutput_in_mem 32 (address/result), StoreData_in_mem 32, Immediate_in_mem 32, Rdst_in_mem 5, MemRead_in_mem 1, MemWrite_in_mem 1, halt_in_mem 1 (all inputs).
REQ-005 SHALL have port: stall_out  out  1  upstream holds all *_in_mem inputs while high.
REQ-006 SHALL have data-memory ports: mem_req out 1, mem_we out 1, mem_addr out 32 (word-aligned), mem_wdata out 32, mem_be out 4, mem_rdata in 32, mem_ack in 1.
REQ-007 SHALL have registered WB-side outputs feeding the writeback stage: valid_out 1, PC_out 32, Inst_out 32, WBSel_out 2, LoadExtended_out 32, Immediate_out 32, ALUOutput_out 32, Rdst_out 5, halt_out 1, fault_out 2 (bit0 misaligned/illegal size, bit1 timeout).

Function
REQ-008 SHALL decode size from Inst_in_mem[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes on a memory op SHALL be illegal (fault_out[0]).
REQ-009 SHALL treat H misaligned when addr[0]=1, W misaligned when addr[1:0]!=0; B never misaligned.
REQ-010 SHALL implement FSM states IDLE and BUSY; reset state IDLE.
REQ-011 IDLE, valid_in=1, no memory op: SHALL register all fields into WB outputs next edge, valid_out=1, stall_out=0 (latency 1).
REQ-012 IDLE, valid_in=0: SHALL write bubble next edge (valid_out=0, Rdst_out=0, halt_out=0, fault_out=0).
REQ-013 IDLE, legal aligned memory op: stall_out=1 combinationally; next edge SHALL register mem_req=1, mem_we=MemWrite, mem_addr={addr[31:2],2'b00}, mem_be, mem_wdata, go BUSY, write bubble to WB outputs.
REQ-014 Store byte enables/data: B be=0001<<addr[1:0], wdata=byte replicated x4; H be=addr[1]?1100:0011, wdata=half replicated x2; W be=1111, wdata=StoreData.
REQ-015 BUSY: mem_req/mem_addr/mem_we/mem_be/mem_wdata SHALL hold stable until mem_ack; stall_out=!mem_ack.
REQ-016 BUSY with mem_ack=1: next edge SHALL clear mem_req, return to IDLE, register WB outputs from held inputs with valid_out=1, LoadExtended_out from mem_rdata (store: LoadExtended_out=0).
REQ-017 Load extension: select byte rdata[8*addr[1:0]+:8] / half rdata[16*addr[1]+:16]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-018 SHALL keep wait counter, cleared on entering BUSY, incremented each BUSY cycle without ack; at count==MAX_WAIT without ack: stall_out=0, next edge mem_req=0, IDLE, valid_out=1, fault_out[1]=1, Rdst_out=0.
REQ-019 Misaligned/illegal memory op in IDLE: SHALL issue no request, stall_out=0, next edge valid_out=1, fault_out[0]=1, Rdst_out=0.
REQ-020 halt_in_mem=1 SHALL propagate to halt_out and force Rdst_out=0; a halting memory op SHALL still complete its access.
REQ-021 mem_ack while IDLE SHALL be ignored.
REQ-022 MemRead and MemWrite both high SHALL be treated as illegal (fault_out[0]).

Reset
REQ-023 RST=1 at an edge SHALL force IDLE, counter=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, and all WB outputs 0, regardless of state, including mid-BUSY.
REQ-024 A mem_ack arriving after a mid-BUSY reset SHALL be ignored; stall_out=0 during and after reset until a new op.

Verification
REQ-025 ALU op, Rdst=5, ALUOutput=0x1234 -> next cycle valid_out=1, Rdst_out=5, ALUOutput_out=0x1234, stall never high.
REQ-026 LB addr 0x1003, ack after 3 BUSY cycles, rdata=0x80FFFFFF -> mem_addr=0x1000, stall high 4 cycles, LoadExtended_out=0xFFFFFF80; LBU same -> 0x00000080.
REQ-027 SH addr 0x2002, StoreData=0xABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, valid_out=1 after ack.
REQ-028 LW addr 0x3001 -> no mem_req, valid_out=1, fault_out=01, Rdst_out=0, no stall.
REQ-029 LW with no ack, MAX_WAIT=15 -> mem_req drops after 15 BUSY cycles, fault_out=10, valid_out=1.
REQ-030 RST asserted in 2nd BUSY cycle, then ack -> mem_req=0, IDLE, all outputs 0, ack ignored.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one word-aligned data-memory access per load/store,
// stalls upstream while the access is outstanding, extends load data and flags
// misaligned/illegal accesses and memory timeouts to the writeback stage.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  // EX/MEM pipeline register
  input  logic        valid_in,
  input  logic [31:0] PC_in_mem,
  input  logic [31:0] Inst_in_mem,
  input  logic [1:0]  WBSel_in_mem,
  input  logic [31:0] ALUOutput_in_mem,
  input  logic [31:0] StoreData_in_mem,
  input  logic [31:0] Immediate_in_mem,
  input  logic [4:0]  Rdst_in_mem,
  input  logic        MemRead_in_mem,
  input  logic        MemWrite_in_mem,
  input  logic        halt_in_mem,
  output logic        stall_out,
  // Data memory
  mem_stage_if.master mem_bus,
  // MEM/WB pipeline register
  output logic        valid_out,
  output logic [31:0] PC_out,
  output logic [31:0] Inst_out,
  output logic [1:0]  WBSel_out,
  output logic [31:0] LoadExtended_out,
  output logic [31:0] Immediate_out,
  output logic [31:0] ALUOutput_out,
  output logic [4:0]  Rdst_out,
  output logic        halt_out,
  output logic [1:0]  fault_out
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;

  logic        req_d, we_d;
  logic [31:0] addr_d, wdata_d;
  logic [3:0]  be_d;

  logic        valid_d, halt_d;
  logic [31:0] pc_d, inst_d, ldext_d, imm_d, alu_d;
  logic [1:0]  wbsel_d, fault_d;
  logic [4:0]  rdst_d;

  logic [2:0]  size;
  logic [1:0]  offs;
  logic        is_mem, size_ok, misaligned, op_fault, op_go;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        take;

  assign size = Inst_in_mem[14:12];
  assign offs = ALUOutput_in_mem[1:0];

  // Size legality and alignment of the current memory op
  always_comb begin
    size_ok    = 1'b0;
    misaligned = 1'b0;
    case (size)
      3'b000, 3'b100: size_ok = 1'b1;
      3'b001, 3'b101: begin
        size_ok    = 1'b1;
        misaligned = offs[0];
      end
      3'b010: begin
        size_ok    = 1'b1;
        misaligned = (offs != 2'b00);
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign is_mem   = MemRead_in_mem | MemWrite_in_mem;
  // Simultaneous read and write is never a legal access
  assign op_fault = is_mem & (!size_ok | misaligned | (MemRead_in_mem & MemWrite_in_mem));
  assign op_go    = valid_in & is_mem & !op_fault;

  // Byte lanes and replicated store data for the addressed word
  always_comb begin
    be_lane    = 4'b0000;
    wdata_lane = 32'h0;
    case (size[1:0])
      2'b00: begin
        be_lane    = 4'b0001 << offs;
        wdata_lane = {4{StoreData_in_mem[7:0]}};
      end
      2'b01: begin
        be_lane    = offs[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{StoreData_in_mem[15:0]}};
      end
      default: begin
        be_lane    = 4'b1111;
        wdata_lane = StoreData_in_mem;
      end
    endcase
  end

  // Lane select and sign/zero extension of returned load data
  always_comb begin
    byte_sel = mem_bus.mem_rdata[{offs, 3'b000} +: 8];
    half_sel = offs[1] ? mem_bus.mem_rdata[31:16] : mem_bus.mem_rdata[15:0];
    case (size)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem_bus.mem_rdata;
    endcase
  end

  // FSM next state, bus request, WB register next values and upstream stall
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    req_d     = mem_bus.mem_req;
    we_d      = mem_bus.mem_we;
    addr_d    = mem_bus.mem_addr;
    wdata_d   = mem_bus.mem_wdata;
    be_d      = mem_bus.mem_be;
    stall_out = 1'b0;
    take      = 1'b0;
    // WB register defaults to a bubble
    valid_d   = 1'b0;
    pc_d      = 32'h0;
    inst_d    = 32'h0;
    wbsel_d   = 2'b00;
    ldext_d   = 32'h0;
    imm_d     = 32'h0;
    alu_d     = 32'h0;
    rdst_d    = 5'd0;
    halt_d    = 1'b0;
    fault_d   = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (op_go) begin
          stall_out = 1'b1;
          req_d     = 1'b1;
          we_d      = MemWrite_in_mem;
          addr_d    = {ALUOutput_in_mem[31:2], 2'b00};
          be_d      = be_lane;
          wdata_d   = MemWrite_in_mem ? wdata_lane : 32'h0;
          wait_d    = 8'd0;
          state_d   = StBusy;
        end else if (valid_in) begin
          take    = 1'b1;
          fault_d = {1'b0, op_fault};
          rdst_d  = (halt_in_mem | op_fault) ? 5'd0 : Rdst_in_mem;
        end
      end
      StBusy: begin
        if (mem_bus.mem_ack) begin
          take    = 1'b1;
          state_d = StIdle;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          ldext_d = MemRead_in_mem ? load_ext : 32'h0;
          rdst_d  = halt_in_mem ? 5'd0 : Rdst_in_mem;
        end else if (wait_q == MaxWait) begin
          take    = 1'b1;
          state_d = StIdle;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          fault_d = 2'b10;
        end else begin
          stall_out = 1'b1;
          wait_d    = wait_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      valid_d = 1'b1;
      pc_d    = PC_in_mem;
      inst_d  = Inst_in_mem;
      wbsel_d = WBSel_in_mem;
      imm_d   = Immediate_in_mem;
      alu_d   = ALUOutput_in_mem;
      halt_d  = halt_in_mem;
    end

    // Upstream never sees a stall while reset is being applied
    if (RST) stall_out = 1'b0;
  end

  // State, bus and WB registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q           <= StIdle;
      wait_q            <= 8'd0;
      mem_bus.mem_req   <= 1'b0;
      mem_bus.mem_we    <= 1'b0;
      mem_bus.mem_addr  <= 32'h0;
      mem_bus.mem_wdata <= 32'h0;
      mem_bus.mem_be    <= 4'b0000;
      valid_out         <= 1'b0;
      PC_out            <= 32'h0;
      Inst_out          <= 32'h0;
      WBSel_out         <= 2'b00;
      LoadExtended_out  <= 32'h0;
      Immediate_out     <= 32'h0;
      ALUOutput_out     <= 32'h0;
      Rdst_out          <= 5'd0;
      halt_out          <= 1'b0;
      fault_out         <= 2'b00;
    end else begin
      state_q           <= state_d;
      wait_q            <= wait_d;
      mem_bus.mem_req   <= req_d;
      mem_bus.mem_we    <= we_d;
      mem_bus.mem_addr  <= addr_d;
      mem_bus.mem_wdata <= wdata_d;
      mem_bus.mem_be    <= be_d;
      valid_out         <= valid_d;
      PC_out            <= pc_d;
      Inst_out          <= inst_d;
      WBSel_out         <= wbsel_d;
      LoadExtended_out  <= ldext_d;
      Immediate_out     <= imm_d;
      ALUOutput_out     <= alu_d;
      Rdst_out          <= rdst_d;
      halt_out          <= halt_d;
      fault_out         <= fault_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] PC_in_mem = 32'h0;
  logic [31:0] Inst_in_mem = 32'h0;
  logic [1:0]  WBSel_in_mem = 2'b00;
  logic [31:0] ALUOutput_in_mem = 32'h0;
  logic [31:0] StoreData_in_mem = 32'h0;
  logic [31:0] Immediate_in_mem = 32'h0;
  logic [4:0]  Rdst_in_mem = 5'd0;
  logic        MemRead_in_mem = 1'b0;
  logic        MemWrite_in_mem = 1'b0;
  logic        halt_in_mem = 1'b0;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] PC_out;
  logic [31:0] Inst_out;
  logic [1:0]  WBSel_out;
  logic [31:0] LoadExtended_out;
  logic [31:0] Immediate_out;
  logic [31:0] ALUOutput_out;
  logic [4:0]  Rdst_out;
  logic        halt_out;
  logic [1:0]  fault_out;

  mem_stage_if mem_bus ();

  mem_stage #(.MAX_WAIT(15)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .valid_in         (valid_in),
    .PC_in_mem        (PC_in_mem),
    .Inst_in_mem      (Inst_in_mem),
    .WBSel_in_mem     (WBSel_in_mem),
    .ALUOutput_in_mem (ALUOutput_in_mem),
    .StoreData_in_mem (StoreData_in_mem),
    .Immediate_in_mem (Immediate_in_mem),
    .Rdst_in_mem      (Rdst_in_mem),
    .MemRead_in_mem   (MemRead_in_mem),
    .MemWrite_in_mem  (MemWrite_in_mem),
    .halt_in_mem      (halt_in_mem),
    .stall_out        (stall_out),
    .mem_bus          (mem_bus),
    .valid_out        (valid_out),
    .PC_out           (PC_out),
    .Inst_out         (Inst_out),
    .WBSel_out        (WBSel_out),
    .LoadExtended_out (LoadExtended_out),
    .Immediate_out    (Immediate_out),
    .ALUOutput_out    (ALUOutput_out),
    .Rdst_out         (Rdst_out),
    .halt_out         (halt_out),
    .fault_out        (fault_out)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3);
    return {17'h0, f3, 5'd0, 7'h03};
  endfunction

  task automatic set_in(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] rd, input logic mr,
                        input logic mw, input logic hlt);
    valid_in         = 1'b1;
    PC_in_mem        = pc;
    Inst_in_mem      = mk_inst(f3);
    WBSel_in_mem     = 2'b01;
    ALUOutput_in_mem = alu;
    StoreData_in_mem = sd;
    Immediate_in_mem = 32'h0000_0010;
    Rdst_in_mem      = rd;
    MemRead_in_mem   = mr;
    MemWrite_in_mem  = mw;
    halt_in_mem      = hlt;
  endtask

  // Issues the already-driven memory op, acks after `waits` BUSY cycles without ack.
  task automatic mem_op(input int waits, input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic exp_we, output int stalls);
    stalls = 0;
    if (stall_out) stalls++;
    step();
    check("busy_req", mem_bus.mem_req, 1);
    check("busy_addr", mem_bus.mem_addr, exp_addr);
    check("busy_be", mem_bus.mem_be, exp_be);
    check("busy_wdata", mem_bus.mem_wdata, exp_wdata);
    check("busy_we", mem_bus.mem_we, exp_we);
    check("busy_bubble", valid_out, 0);
    for (int i = 0; i < waits; i++) begin
      if (stall_out) stalls++;
      step();
    end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = rdata;
    #1;
    if (stall_out) stalls++;
    check("hold_addr", mem_bus.mem_addr, exp_addr);
    check("hold_req", mem_bus.mem_req, 1);
    step();
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    valid_in          = 1'b0;
    MemRead_in_mem    = 1'b0;
    MemWrite_in_mem   = 1'b0;
  endtask

  int stalls;
  int n_req;
  int n_stall;
  int stall_seen;

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;

    // Reset state
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    check("rst_valid", valid_out, 0);
    check("rst_req", mem_bus.mem_req, 0);
    check("rst_stall", stall_out, 0);
    check("rst_addr", mem_bus.mem_addr, 0);

    // ALU op passes through with latency 1
    set_in(32'h0000_0100, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0);
    #1;
    check("alu_stall", stall_out, 0);
    step();
    check("alu_valid", valid_out, 1);
    check("alu_rdst", Rdst_out, 5);
    check("alu_res", ALUOutput_out, 32'h0000_1234);
    check("alu_pc", PC_out, 32'h0000_0100);
    check("alu_imm", Immediate_out, 32'h0000_0010);
    check("alu_wbsel", WBSel_out, 2'b01);
    check("alu_stall2", stall_out, 0);
    valid_in = 1'b0;
    step();
    check("bubble_valid", valid_out, 0);
    check("bubble_rdst", Rdst_out, 0);

    // LB at 0x1003, ack after 3 BUSY cycles
    set_in(32'h0000_0200, 3'b000, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    check("lb_stall0", stall_out, 1);
    mem_op(3, 32'h80FF_FFFF, 32'h0000_1000, 4'b1000, 32'h0, 1'b0, stalls);
    check("lb_stalls", stalls, 4);
    check("lb_valid", valid_out, 1);
    check("lb_data", LoadExtended_out, 32'hFFFF_FF80);
    check("lb_rdst", Rdst_out, 7);
    check("lb_req_clr", mem_bus.mem_req, 0);
    step();

    // LBU same access
    set_in(32'h0000_0204, 3'b100, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    mem_op(3, 32'h80FF_FFFF, 32'h0000_1000, 4'b1000, 32'h0, 1'b0, stalls);
    check("lbu_stalls", stalls, 4);
    check("lbu_data", LoadExtended_out, 32'h0000_0080);
    step();

    // SH at 0x2002
    set_in(32'h0000_0300, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    mem_op(0, 32'hFFFF_FFFF, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 1'b1, stalls);
    check("sh_stalls", stalls, 1);
    check("sh_valid", valid_out, 1);
    check("sh_ldext", LoadExtended_out, 0);
    step();

    // SB at 0x6001
    set_in(32'h0000_0304, 3'b000, 32'h0000_6001, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    mem_op(1, 32'h0, 32'h0000_6000, 4'b0010, 32'h7878_7878, 1'b1, stalls);
    check("sb_stalls", stalls, 2);
    step();

    // LHU at 0x4002 selects upper half, zero-extended
    set_in(32'h0000_0400, 3'b101, 32'h0000_4002, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    mem_op(2, 32'h8001_1234, 32'h0000_4000, 4'b1100, 32'h0, 1'b0, stalls);
    check("lhu_data", LoadExtended_out, 32'h0000_8001);
    step();

    // LH at 0x4000 selects lower half, sign-extended
    set_in(32'h0000_0404, 3'b001, 32'h0000_4000, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    mem_op(0, 32'h0001_9234, 32'h0000_4000, 4'b0011, 32'h0, 1'b0, stalls);
    check("lh_data", LoadExtended_out, 32'hFFFF_9234);
    step();

    // LW pass-through, halting op still completes
    set_in(32'h0000_0500, 3'b010, 32'h0000_5000, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
    #1;
    mem_op(1, 32'hDEAD_BEEF, 32'h0000_5000, 4'b1111, 32'h0, 1'b0, stalls);
    check("lw_data", LoadExtended_out, 32'hDEAD_BEEF);
    check("lw_halt", halt_out, 1);
    check("lw_halt_rdst", Rdst_out, 0);
    halt_in_mem = 1'b0;
    step();

    // Misaligned LW at 0x3001
    set_in(32'h0000_0600, 3'b010, 32'h0000_3001, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    check("mis_stall", stall_out, 0);
    step();
    check("mis_req", mem_bus.mem_req, 0);
    check("mis_valid", valid_out, 1);
    check("mis_fault", fault_out, 2'b01);
    check("mis_rdst", Rdst_out, 0);

    // Illegal size code 011
    set_in(32'h0000_0604, 3'b011, 32'h0000_3000, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    check("ill_fault", fault_out, 2'b01);
    check("ill_req", mem_bus.mem_req, 0);

    // Read and write together
    set_in(32'h0000_0608, 3'b010, 32'h0000_3000, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    step();
    check("rw_fault", fault_out, 2'b01);
    check("rw_req", mem_bus.mem_req, 0);

    // Halting ALU op
    set_in(32'h0000_0700, 3'b000, 32'h0000_0055, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1);
    step();
    check("halt_out", halt_out, 1);
    check("halt_rdst", Rdst_out, 0);
    halt_in_mem = 1'b0;
    valid_in    = 1'b0;
    step();

    // LW with no ack: aborts in the BUSY cycle where the wait count reaches 15
    set_in(32'h0000_0800, 3'b010, 32'h0000_7000, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    step();
    n_req      = 0;
    n_stall    = 0;
    stall_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_bus.mem_req) break;
      n_req++;
      if (stall_out) n_stall++;
      step();
    end
    check("to_req_cycles", n_req, 16);
    check("to_stall_cycles", n_stall, 15);
    check("to_valid", valid_out, 1);
    check("to_fault", fault_out, 2'b10);
    check("to_rdst", Rdst_out, 0);
    valid_in       = 1'b0;
    MemRead_in_mem = 1'b0;
    step();

    // Reset in the 2nd BUSY cycle, then a stray ack
    set_in(32'h0000_0900, 3'b010, 32'h0000_8000, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
    step();
    step();
    RST      = 1'b1;
    valid_in = 1'b0;
    #1;
    check("rst_busy_stall", stall_out, 0);
    step();
    RST = 1'b0;
    check("rst_busy_req", mem_bus.mem_req, 0);
    check("rst_busy_addr", mem_bus.mem_addr, 0);
    check("rst_busy_be", mem_bus.mem_be, 0);
    check("rst_busy_valid", valid_out, 0);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h1234_5678;
    #1;
    if (stall_out) stall_seen++;
    step();
    mem_bus.mem_ack = 1'b0;
    check("stray_ack_valid", valid_out, 0);
    check("stray_ack_req", mem_bus.mem_req, 0);
    check("stray_ack_ldext", LoadExtended_out, 0);
    check("stray_ack_stall", stall_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
